seg7_scan_display: RTL and testbench



---
 rtl/seg7_pkg.sv | 23 ++
 rtl/hex_to_seg7.sv | 13 +
 rtl/seg7_scan_display.sv | 146 ++++++++++++++
 tb/tb_seg7_scan_display.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and elaboration helpers for the multi-digit 7-segment scan controller.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

  // Active-high gfedcba patterns for hex digits 0..F
  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned scan_hz);
    return clk_hz / scan_hz;
  endfunction

  // Counter width for values 0..n-1, never narrower than one bit
  function automatic int unsigned calc_sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-high gfedcba segment decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0]       i_nibble,
  output logic [SEG_W-1:0] o_seg_c
);

  always_comb begin
    o_seg_c = SEG_TABLE[i_nibble];
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Multi-digit 7-segment scan controller: divider, digit scan, blink timing,
// per-digit dp/blank/blink and polarity-adjusted registered display outputs.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned CLK_HZ         = 50000000,
  parameter int unsigned SCAN_HZ        = 800,
  parameter int unsigned BLINK_FRAMES   = 50,
  parameter bit          DS_ACTIVE_LOW  = 1'b0,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  localparam int unsigned SEL_W         = calc_sel_w(NUM_DIGITS)
) (
  input  logic                    clk_50mhz,
  input  logic                    rst,
  input  logic                    n_en,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   blink,
  output logic [NUM_DIGITS-1:0]   ds,
  output logic [SEG_W-1:0]        led,
  output logic                    dp,
  output logic [SEL_W-1:0]        sel,
  output logic                    frame_tick
);

  localparam int unsigned DIV   = calc_div(CLK_HZ, SCAN_HZ);
  localparam int unsigned DIV_W = calc_sel_w(DIV);
  localparam int unsigned BC_W  = calc_sel_w(BLINK_FRAMES);

  if (DIV < 2) begin : g_bad_div
    $error("seg7_scan_display: CLK_HZ/SCAN_HZ must be at least 2");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_digits
    $error("seg7_scan_display: NUM_DIGITS must be 1..16");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("seg7_scan_display: BLINK_FRAMES must be at least 1");
  end

  logic [DIV_W-1:0]      r_div_cnt;
  logic [SEL_W-1:0]      r_sel;
  logic [BC_W-1:0]       r_blink_cnt;
  logic                  r_blink_phase;
  logic                  r_frame_tick;
  logic [NUM_DIGITS-1:0] r_ds;
  logic [SEG_W-1:0]      r_led;
  logic                  r_dp;

  logic                  w_scan_tick;
  logic                  w_wrap;
  logic [SEL_W-1:0]      w_sel_next;
  logic                  w_blink_phase_next;
  logic [3:0]            w_nibble;
  logic                  w_dp_sel;
  logic                  w_dark;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic [SEG_W-1:0]      w_seg;
  logic [NUM_DIGITS-1:0] w_ds_next;
  logic [SEG_W-1:0]      w_led_next;
  logic                  w_dp_next;

  assign w_scan_tick = (r_div_cnt == DIV_W'(DIV - 1));
  assign w_wrap      = w_scan_tick && (r_sel == SEL_W'(NUM_DIGITS - 1));

  always_comb begin
    w_sel_next = r_sel;
    if (w_scan_tick) begin
      w_sel_next = w_wrap ? '0 : r_sel + SEL_W'(1);
    end
  end

  always_comb begin
    w_blink_phase_next = r_blink_phase;
    if (w_wrap && (r_blink_cnt == BC_W'(BLINK_FRAMES - 1))) begin
      w_blink_phase_next = ~r_blink_phase;
    end
  end

  // Per-digit attributes of the digit that will be driven after this edge
  always_comb begin
    w_nibble = '0;
    w_dp_sel = 1'b0;
    w_dark   = 1'b0;
    w_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_sel_next == SEL_W'(i)) begin
        w_nibble    = data[4*i +: 4];
        w_dp_sel    = dp_in[i];
        w_dark      = blank[i] | (blink[i] & w_blink_phase_next);
        w_onehot[i] = 1'b1;
      end
    end
  end

  hex_to_seg7 u_dec (
    .i_nibble (w_nibble),
    .o_seg_c  (w_seg)
  );

  // Dark digits keep their select active so the scan duty stays uniform
  always_comb begin
    w_ds_next  = '0;
    w_led_next = SEG_OFF;
    w_dp_next  = 1'b0;
    if (!n_en) begin
      w_ds_next = w_onehot;
      if (!w_dark) begin
        w_led_next = w_seg;
        w_dp_next  = w_dp_sel;
      end
    end
  end

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      r_div_cnt     <= '0;
      r_sel         <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_frame_tick  <= 1'b0;
      r_ds          <= '0;
      r_led         <= SEG_OFF;
      r_dp          <= 1'b0;
    end else begin
      r_div_cnt     <= w_scan_tick ? '0 : r_div_cnt + DIV_W'(1);
      r_sel         <= w_sel_next;
      r_blink_phase <= w_blink_phase_next;
      r_frame_tick  <= w_wrap;
      if (w_wrap) begin
        r_blink_cnt <= (r_blink_cnt == BC_W'(BLINK_FRAMES - 1)) ? '0 : r_blink_cnt + BC_W'(1);
      end
      r_ds  <= w_ds_next;
      r_led <= w_led_next;
      r_dp  <= w_dp_next;
    end
  end

  assign ds         = r_ds ^ {NUM_DIGITS{DS_ACTIVE_LOW}};
  assign led        = r_led ^ {SEG_W{SEG_ACTIVE_LOW}};
  assign dp         = r_dp ^ SEG_ACTIVE_LOW;
  assign sel        = r_sel;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: two instances (normal and inverted polarity) checked
// every cycle against an edge-count based model, plus vector tables and corner sequences.
module tb_seg7_scan_display;

  localparam int unsigned ND  = 4;
  localparam int unsigned DV  = 8;
  localparam int unsigned BF  = 2;
  localparam int unsigned FRM = DV * ND;

  logic        clk_50mhz = 1'b0;
  logic        rst_a = 1'b1;
  logic        rst_b = 1'b1;
  logic        n_en  = 1'b0;
  logic [15:0] data  = 16'h3210;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blank = 4'h0;
  logic [3:0]  blink = 4'h0;

  logic [3:0]  ds_a, ds_b;
  logic [6:0]  led_a, led_b;
  logic        dp_a, dp_b;
  logic [1:0]  sel_a, sel_b;
  logic        ft_a, ft_b;

  int checks = 0;
  int errors = 0;
  int n_a = 0;
  int n_b = 0;

  logic [6:0] seg_ref [16];

  always #5 clk_50mhz = ~clk_50mhz;

  seg7_scan_display #(
    .NUM_DIGITS(ND), .CLK_HZ(80), .SCAN_HZ(10), .BLINK_FRAMES(BF),
    .DS_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0)
  ) dut_a (
    .clk_50mhz(clk_50mhz), .rst(rst_a), .n_en(n_en), .data(data), .dp_in(dp_in),
    .blank(blank), .blink(blink), .ds(ds_a), .led(led_a), .dp(dp_a),
    .sel(sel_a), .frame_tick(ft_a)
  );

  seg7_scan_display #(
    .NUM_DIGITS(ND), .CLK_HZ(80), .SCAN_HZ(10), .BLINK_FRAMES(BF),
    .DS_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) dut_b (
    .clk_50mhz(clk_50mhz), .rst(rst_b), .n_en(n_en), .data(data), .dp_in(dp_in),
    .blank(blank), .blink(blink), .ds(ds_b), .led(led_b), .dp(dp_b),
    .sel(sel_b), .frame_tick(ft_b)
  );

  // Clock edges seen since each instance left reset
  always @(posedge clk_50mhz or posedge rst_a) begin
    if (rst_a) n_a <= 0;
    else       n_a <= n_a + 1;
  end
  always @(posedge clk_50mhz or posedge rst_b) begin
    if (rst_b) n_b <= 0;
    else       n_b <= n_b + 1;
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outputs after n edges, from the scan/blink timing rules directly
  task automatic check_model(input string tag, input int n, input bit inv,
                             input logic [3:0] ds_o, input logic [6:0] led_o, input logic dp_o,
                             input logic [1:0] sel_o, input logic ft_o);
    int         s, phase;
    logic [3:0] e_ds;
    logic [6:0] e_led;
    logic       e_dp, e_ft, dark;
    s     = (n / DV) % ND;
    phase = ((n / FRM) / BF) % 2;
    e_ds  = 4'h0;
    e_led = 7'h00;
    e_dp  = 1'b0;
    e_ft  = 1'b0;
    if (n > 0) begin
      e_ft = (n % FRM) == 0;
      dark = blank[s] | (blink[s] & (phase == 1));
      if (!n_en) begin
        e_ds = 4'(1 << s);
        if (!dark) begin
          e_led = seg_ref[(data >> (4 * s)) & 16'hF];
          e_dp  = dp_in[s];
        end
      end
    end
    if (inv) begin
      e_ds  = ~e_ds;
      e_led = ~e_led;
      e_dp  = ~e_dp;
    end
    cmp({tag, ".ds"},         32'(ds_o),  32'(e_ds));
    cmp({tag, ".led"},        32'(led_o), 32'(e_led));
    cmp({tag, ".dp"},         32'(dp_o),  32'(e_dp));
    cmp({tag, ".sel"},        32'(sel_o), 32'(s));
    cmp({tag, ".frame_tick"}, 32'(ft_o),  32'(e_ft));
  endtask

  // Advance one clock, check both instances, then leave room for stimulus changes
  task automatic next();
    @(negedge clk_50mhz);
    check_model("A", n_a, 1'b0, ds_a, led_a, dp_a, sel_a, ft_a);
    check_model("B", n_b, 1'b1, ds_b, led_b, dp_b, sel_b, ft_b);
    #1;
  endtask

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    int          sel;
    logic [3:0]  ds;
    logic [6:0]  led;
    logic        dp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int budget, pulses;
    logic [6:0] blink_exp [5];

    seg_ref = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    blink_exp = '{7'h3F, 7'h3F, 7'h00, 7'h00, 7'h3F};

    vecs.push_back('{16'h3210, 4'b0000, 4'b0000, 0, 4'b0001, 7'h3F, 1'b0});
    vecs.push_back('{16'h3210, 4'b0000, 4'b0000, 1, 4'b0010, 7'h06, 1'b0});
    vecs.push_back('{16'h3210, 4'b0000, 4'b0000, 2, 4'b0100, 7'h5B, 1'b0});
    vecs.push_back('{16'h3210, 4'b0000, 4'b0000, 3, 4'b1000, 7'h4F, 1'b0});
    vecs.push_back('{16'hFEDC, 4'b0101, 4'b0000, 0, 4'b0001, 7'h39, 1'b1});
    vecs.push_back('{16'hFEDC, 4'b0101, 4'b0000, 1, 4'b0010, 7'h5E, 1'b0});
    vecs.push_back('{16'hFEDC, 4'b0101, 4'b0000, 2, 4'b0100, 7'h79, 1'b1});
    vecs.push_back('{16'hFEDC, 4'b0101, 4'b0000, 3, 4'b1000, 7'h71, 1'b0});
    vecs.push_back('{16'hFEDC, 4'b0101, 4'b0010, 1, 4'b0010, 7'h00, 1'b0});
    vecs.push_back('{16'hFEDC, 4'b0101, 4'b0010, 2, 4'b0100, 7'h79, 1'b1});
    vecs.push_back('{16'hFEDC, 4'b0101, 4'b0010, 0, 4'b0001, 7'h39, 1'b1});
    vecs.push_back('{16'h9764, 4'b0000, 4'b0000, 0, 4'b0001, 7'h66, 1'b0});
    vecs.push_back('{16'h9764, 4'b0000, 4'b0000, 1, 4'b0010, 7'h7D, 1'b0});
    vecs.push_back('{16'h9764, 4'b0000, 4'b0000, 2, 4'b0100, 7'h07, 1'b0});
    vecs.push_back('{16'h9764, 4'b0000, 4'b0000, 3, 4'b1000, 7'h6F, 1'b0});
    vecs.push_back('{16'hA8B5, 4'b1000, 4'b0000, 0, 4'b0001, 7'h6D, 1'b0});
    vecs.push_back('{16'hA8B5, 4'b1000, 4'b0000, 1, 4'b0010, 7'h7C, 1'b0});
    vecs.push_back('{16'hA8B5, 4'b1000, 4'b0000, 2, 4'b0100, 7'h7F, 1'b0});
    vecs.push_back('{16'hA8B5, 4'b1000, 4'b0000, 3, 4'b1000, 7'h77, 1'b1});

    // Reset state, then release and watch the first edge select digit 0
    repeat (3) next();
    rst_a = 1'b0;
    rst_b = 1'b0;
    next();
    cmp("first_edge.ds", 32'(ds_a), 32'h1);
    cmp("first_edge.led", 32'(led_a), 32'h3F);

    pulses = 0;
    for (int i = 0; i < 4 * FRM; i++) begin
      next();
      if (ft_a) pulses++;
    end
    cmp("frame_tick_count", 32'(pulses), 32'd4);

    // Vector table: wait for the target digit, compare against hand-decoded values
    foreach (vecs[k]) begin
      data   = vecs[k].data;
      dp_in  = vecs[k].dp_in;
      blank  = vecs[k].blank;
      budget = 0;
      do begin
        next();
        budget++;
      end while (((n_a / DV) % ND) != vecs[k].sel && budget < 64);
      if (budget >= 64) cmp("vec_timeout", 32'(budget), 32'd0);
      cmp($sformatf("vec%0d.ds", k),  32'(ds_a),  32'(vecs[k].ds));
      cmp($sformatf("vec%0d.led", k), 32'(led_a), 32'(vecs[k].led));
      cmp($sformatf("vec%0d.dp", k),  32'(dp_a),  32'(vecs[k].dp));
    end

    // Blink on digit 0: lit frames 0-1, dark 2-3, lit again at frame 4
    data  = 16'h3210;
    dp_in = 4'h0;
    blank = 4'h0;
    blink = 4'b0001;
    rst_a = 1'b1;
    next();
    rst_a = 1'b0;
    for (int f = 0; f < 5; f++) begin
      budget = 0;
      while (n_a < f * FRM + 2 && budget < 200) begin
        next();
        budget++;
      end
      cmp($sformatf("blink_f%0d.ds", f),  32'(ds_a),  32'h1);
      cmp($sformatf("blink_f%0d.led", f), 32'(led_a), 32'(blink_exp[f]));
    end
    blink = 4'h0;

    // Enable drop mid-frame: dark next edge, scan keeps counting, resumes in place
    repeat (5) next();
    n_en = 1'b1;
    next();
    cmp("n_en_off.ds", 32'(ds_a), 32'h0);
    cmp("n_en_off.led", 32'(led_a), 32'h0);
    repeat (13) next();
    cmp("n_en_off.sel", 32'(sel_a), 32'((n_a / DV) % ND));
    n_en = 1'b0;
    next();
    cmp("n_en_on.ds", 32'(ds_a), 32'(4'(1 << ((n_a / DV) % ND))));

    // Inverted-polarity instance: asynchronous reset between clock edges
    repeat (11) next();
    #2;
    rst_b = 1'b1;
    #1;
    cmp("async_rst.ds", 32'(ds_b), 32'hF);
    cmp("async_rst.led", 32'(led_b), 32'h7F);
    cmp("async_rst.dp", 32'(dp_b), 32'h1);
    cmp("async_rst.sel", 32'(sel_b), 32'h0);
    next();
    rst_b = 1'b0;
    next();
    cmp("post_rst.ds", 32'(ds_b), 32'hE);
    cmp("post_rst.led", 32'(led_b), 32'h40);

    // Randomized inputs against the model
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        data  = 16'($urandom);
        dp_in = 4'($urandom);
        blank = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
        blink = 4'($urandom);
        n_en  = ($urandom_range(0, 7) == 0);
      end
      next();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
